// File: rtl/brent_kung_prefix_pipe.sv
// Brent-Kung 4-bit carry-prefix tree with valid/ready pipelining: up-sweep stage, then down-sweep and sum stage.
// Define BK_LATENCY1_EN to drop the up-sweep register stage and get single-cycle latency.
module brent_kung_prefix_pipe (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [4:0] P_IN,
    input  logic [4:0] G_IN,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [3:0] S,
    output logic       C_OUT
);
    logic       unusedP0;
    logic       g10Up, p32Up, g32Up, g30Up;
    logic [4:1] s2P;
    logic       s2G0, s2G2, s2G4, s2G10, s2G30, s2Valid;
    logic       ready2;
    logic       g20Dn, g40Dn;
    logic       v2_q, v2_d;
    logic [3:0] s_q, s_d;
    logic       c_q, c_d;

    // Position 0 is pure generate (carry-in), so its propagate bit has no meaning.
    assign unusedP0 = P_IN[0];

    assign g10Up  = G_IN[1] | (P_IN[1] & G_IN[0]);
    assign p32Up  = P_IN[3] & P_IN[2];
    assign g32Up  = G_IN[3] | (P_IN[3] & G_IN[2]);
    assign g30Up  = g32Up | (p32Up & g10Up);
    assign ready2 = !v2_q || OUT_READY;

`ifdef BK_LATENCY1_EN
    assign s2P      = P_IN[4:1];
    assign s2G0     = G_IN[0];
    assign s2G2     = G_IN[2];
    assign s2G4     = G_IN[4];
    assign s2G10    = g10Up;
    assign s2G30    = g30Up;
    assign s2Valid  = IN_VALID;
    assign IN_READY = !RST && ready2;
`else
    logic       v1_q, v1_d, ready1;
    logic [4:1] p_q;
    logic       g0_q, g2_q, g4_q, g10_q, g30_q;

    assign ready1   = !v1_q || ready2;
    assign IN_READY = !RST && ready1;
    assign v1_d     = ready1 ? IN_VALID : v1_q;

    // Up-sweep register stage; loads whenever it is empty or its contents move on.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q  <= 1'b0;
            p_q   <= '0;
            g0_q  <= 1'b0;
            g2_q  <= 1'b0;
            g4_q  <= 1'b0;
            g10_q <= 1'b0;
            g30_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (IN_VALID && ready1) begin
                p_q   <= P_IN[4:1];
                g0_q  <= G_IN[0];
                g2_q  <= G_IN[2];
                g4_q  <= G_IN[4];
                g10_q <= g10Up;
                g30_q <= g30Up;
            end
        end
    end

    assign s2P     = p_q;
    assign s2G0    = g0_q;
    assign s2G2    = g2_q;
    assign s2G4    = g4_q;
    assign s2G10   = g10_q;
    assign s2G30   = g30_q;
    assign s2Valid = v1_q;
`endif

    assign g20Dn = s2G2 | (s2P[2] & s2G10);
    assign g40Dn = s2G4 | (s2P[4] & s2G30);

    // Result registers only change on a stage-2 load, so a stalled output stays stable.
    always_comb begin
        v2_d = ready2 ? s2Valid : v2_q;
        s_d  = s_q;
        c_d  = c_q;
        if (s2Valid && ready2) begin
            s_d = {s2P[4] ^ s2G30, s2P[3] ^ g20Dn, s2P[2] ^ s2G10, s2P[1] ^ s2G0};
            c_d = g40Dn;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v2_q <= 1'b0;
            s_q  <= '0;
            c_q  <= 1'b0;
        end else begin
            v2_q <= v2_d;
            s_q  <= s_d;
            c_q  <= c_d;
        end
    end

    assign OUT_VALID = v2_q && !RST;
    assign S         = s_q;
    assign C_OUT     = c_q;
endmodule

// File: doc/brent_kung_prefix_pipe.md
BRENT_KUNG_PREFIX_PIPE -- requirements
Module: brent_kung_prefix_pipe

Interface
REQ-001 Parameters: none; fixed 4-bit datapath (bit positions 1..4 plus carry-in position 0).
REQ-002 Ports:
CLK  in  1  single clock; all state updates on the rising edge.
RST  in  1  synchronous, active-high reset.
IN_VALID  in  1  P_IN/G_IN hold a valid transaction.
IN_READY  out  1  block accepts a transaction this cycle.
P_IN  in  5  bitwise propagate; bit i is P_i from the bitwise PG stage.
G_IN  in  5  bitwise generate; bit i is G_i, and G_IN[0] carries C_0.
OUT_VALID  out  1  S/C_OUT hold a valid result.
OUT_READY  in  1  downstream accepts the result this cycle.
S  out  4  sum bits; S[i-1] is sum bit i, for i=1..4.
C_OUT  out  1  carry-out, equal to G_{4:0}.

Function
REQ-003 The block SHALL ignore P_IN[0]; position 0 is pure generate.
REQ-004 A transfer SHALL occur on a rising edge where valid and ready are both high; IN_VALID is otherwise ignored.
REQ-005 Stage 1 (up-sweep) SHALL register these terms:
- G10 = G1 | P1&G0; P32 = P3&P2; G32 = G3 | P3&G2;
- G30 = G32 | P32&G10;
- pass-through P_IN[4:1], G2, G4.
REQ-006 Stage 2 (down-sweep and sum) SHALL compute and register:
- G20 = G2 | P2&G10; G40 = G4 | P4&G30;
- S = {P4^G30, P3^G20, P2^G10, P1^G0};
- C_OUT = G40.
REQ-007 Latency SHALL be 2 cycles from input transfer to OUT_VALID high.
REQ-008 Throughput SHALL be 1 transaction/cycle while OUT_READY is high.
REQ-009 Each stage SHALL hold a valid flag.
- A stage loads when it is empty or its contents move forward in the same cycle.
- IN_READY = !v1 | !v2 | OUT_READY.
- IN_READY may depend combinationally on OUT_READY.
REQ-010 While OUT_VALID is high and OUT_READY is low, S, C_OUT and OUT_VALID SHALL hold stable.
REQ-011 With OUT_READY low and both stages full, IN_READY SHALL be low; no transaction is lost, duplicated or reordered.
REQ-012 On simultaneous output drain and input accept with the pipeline full, all stages SHALL advance in that cycle with no bubble.
REQ-013 S and C_OUT SHALL be don't-care while OUT_VALID is low, but SHALL change only on a stage-2 load.

Reset
REQ-014 While RST is high at a rising edge, v1, v2, S, C_OUT and stage-1 registers SHALL clear to 0.
REQ-015 While RST is high, IN_READY and OUT_VALID SHALL be 0 and inputs SHALL be ignored.
REQ-016 RST asserted mid-operation SHALL discard all in-flight transactions.
REQ-017 IN_READY SHALL be 1 on the first cycle after RST deasserts.

Configuration
REQ-018 Macro BK_LATENCY1_EN: when defined, the stage-1 registers and v1 SHALL be removed.
- Up-sweep and down-sweep run combinationally into the stage-2 registers.
- Latency is 1 cycle; IN_READY = !v2 | OUT_READY.
- Without the macro, REQ-005..REQ-009 apply unchanged.

Verification
REQ-019 A=0xB, B=0x6, C_0=1 via the bitwise PG stage, OUT_READY=1 -> two cycles later OUT_VALID=1, S=0x2, C_OUT=1.
REQ-020 A=0xF, B=0x0, C_0=1 (full propagate chain) -> S=0x0, C_OUT=1; same with C_0=0 -> S=0xF, C_OUT=0.
REQ-021 Back-to-back transactions (0x7+0x8+0, then 0x1+0x1+1), OUT_READY=1 -> consecutive cycles S=0xF/C_OUT=0, then S=0x3/C_OUT=0.
REQ-022 Backpressure:
- Stimulus: OUT_READY low for 4 cycles while 3 transactions are offered.
- Response: IN_READY drops after 2 are accepted; S and C_OUT stay stable.
- Response after release: results emerge in order with no loss.
REQ-023 RST pulse one cycle after accepting 2 transactions -> OUT_VALID never rises for them; S=0 and C_OUT=0; IN_READY=1 on the next cycle.
REQ-024 With BK_LATENCY1_EN defined -> REQ-019 stimulus gives OUT_VALID one cycle after the transfer; full-throughput stream unchanged.
